// File: rtl/hazard_controller_if.sv
// Hazard controller port bundle: pipeline hazard inputs and stall/flush/halt controls.
// The pipeline side uses the master modport, the controller uses the slave modport.
interface hazard_controller_if #(
    parameter int unsigned NB_REG_ADDRESS = 5,
    parameter int unsigned NB_STALL_COUNT = 16
);
    logic                      i_enable;
    logic [NB_REG_ADDRESS-1:0] i_rs_if_id;
    logic [NB_REG_ADDRESS-1:0] i_rt_if_id;
    logic [NB_REG_ADDRESS-1:0] i_rt_id_ex;
    logic                      i_mem_read_id_ex;
    logic                      i_branch_taken_id;
    logic                      i_halt_id;
    logic                      o_pc_write;
    logic                      o_if_id_write;
    logic                      o_id_ex_bubble;
    logic                      o_if_id_flush;
    logic                      o_halted;
    logic [NB_STALL_COUNT-1:0] o_stall_count;

    modport master (
        output i_enable, i_rs_if_id, i_rt_if_id, i_rt_id_ex, i_mem_read_id_ex,
               i_branch_taken_id, i_halt_id,
        input  o_pc_write, o_if_id_write, o_id_ex_bubble, o_if_id_flush, o_halted,
               o_stall_count
    );

    modport slave (
        input  i_enable, i_rs_if_id, i_rt_if_id, i_rt_id_ex, i_mem_read_id_ex,
               i_branch_taken_id, i_halt_id,
        output o_pc_write, o_if_id_write, o_id_ex_bubble, o_if_id_flush, o_halted,
               o_stall_count
    );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer: load-use stalls, branch flushes and halt drain.
// Optional feature macro: HAZARD_STALL_COUNTER_EN enables the saturating stall counter.
module hazard_controller #(
    parameter int unsigned NB_REG_ADDRESS = 5,
    parameter int unsigned NB_DRAIN_COUNT = 3,
    parameter int unsigned DRAIN_CYCLES   = 3,
    parameter int unsigned NB_STALL_COUNT = 16
) (
    input logic                 i_clock,
    input logic                 i_reset,
    hazard_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        StRun,
        StLoadStall,
        StDrain,
        StHalted
    } state_e;

    state_e                    state_q;
    logic [NB_DRAIN_COUNT-1:0] drain_cnt_q;
    logic                      halted_q;
    logic                      load_use;
    logic                      load_use_eff;

    assign load_use = bus.i_mem_read_id_ex
                   && (bus.i_rt_id_ex != '0)
                   && ((bus.i_rt_id_ex == bus.i_rs_if_id) || (bus.i_rt_id_ex == bus.i_rt_if_id));

    // Only one stall per load: the hazard is ignored once already stalled.
    assign load_use_eff = load_use && (state_q == StRun);

    always_comb begin
        bus.o_pc_write     = 1'b0;
        bus.o_if_id_write  = 1'b0;
        bus.o_id_ex_bubble = 1'b0;
        bus.o_if_id_flush  = 1'b0;
        if (i_reset) begin
            bus.o_id_ex_bubble = 1'b1;
            bus.o_if_id_flush  = 1'b1;
        end else if (bus.i_enable) begin
            unique case (state_q)
                StRun, StLoadStall: begin
                    if (load_use_eff) begin
                        bus.o_id_ex_bubble = 1'b1;
                    end else if (bus.i_halt_id) begin
                        bus.o_if_id_write = 1'b1;
                        bus.o_if_id_flush = 1'b1;
                    end else if (bus.i_branch_taken_id) begin
                        bus.o_pc_write    = 1'b1;
                        bus.o_if_id_write = 1'b1;
                        bus.o_if_id_flush = 1'b1;
                    end else begin
                        bus.o_pc_write    = 1'b1;
                        bus.o_if_id_write = 1'b1;
                    end
                end
                StDrain: begin
                    bus.o_if_id_write = 1'b1;
                    bus.o_if_id_flush = 1'b1;
                end
                StHalted: begin
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= StRun;
            drain_cnt_q <= '0;
            halted_q    <= 1'b0;
        end else if (bus.i_enable) begin
            unique case (state_q)
                StRun, StLoadStall: begin
                    if (load_use_eff) begin
                        state_q <= StLoadStall;
                    end else if (bus.i_halt_id) begin
                        state_q     <= StDrain;
                        drain_cnt_q <= NB_DRAIN_COUNT'(DRAIN_CYCLES);
                    end else begin
                        state_q <= StRun;
                    end
                end
                StDrain: begin
                    drain_cnt_q <= drain_cnt_q - NB_DRAIN_COUNT'(1);
                    if (drain_cnt_q == NB_DRAIN_COUNT'(1)) begin
                        state_q  <= StHalted;
                        halted_q <= 1'b1;
                    end
                end
                StHalted: begin
                    state_q <= StHalted;
                end
                default: begin
                    state_q <= StRun;
                end
            endcase
        end
    end

    // Reset forces the status outputs low during the reset cycle itself.
    assign bus.o_halted = halted_q && !i_reset;

`ifdef HAZARD_STALL_COUNTER_EN
    logic [NB_STALL_COUNT-1:0] stall_cnt_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            stall_cnt_q <= '0;
        end else if (bus.i_enable && load_use_eff && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + NB_STALL_COUNT'(1);
        end
    end

    assign bus.o_stall_count = i_reset ? '0 : stall_cnt_q;
`else
    assign bus.o_stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: driver queues expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_hazard_controller;

    logic clk;
    logic rst;

    hazard_controller_if #(.NB_REG_ADDRESS(5), .NB_STALL_COUNT(2)) bus_if ();

    hazard_controller #(
        .NB_REG_ADDRESS(5),
        .NB_DRAIN_COUNT(3),
        .DRAIN_CYCLES  (3),
        .NB_STALL_COUNT(2)
    ) u_dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc;
        logic       ifid;
        logic       bub;
        logic       fl;
        logic       hl;
        logic [1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   vec_id   = 0;

    function automatic logic [1:0] ec(input int n);
`ifdef HAZARD_STALL_COUNTER_EN
        return (n > 3) ? 2'd3 : 2'(n);
`else
        return 2'd0;
`endif
    endfunction

    task automatic chk(input string name, input int id, input logic [1:0] act,
                       input logic [1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s vec %0d: got %0d required %0d", name, id, act, req);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc_write",    vec_id, {1'b0, bus_if.o_pc_write},     {1'b0, e.pc});
            chk("if_id_write", vec_id, {1'b0, bus_if.o_if_id_write},  {1'b0, e.ifid});
            chk("bubble",      vec_id, {1'b0, bus_if.o_id_ex_bubble}, {1'b0, e.bub});
            chk("flush",       vec_id, {1'b0, bus_if.o_if_id_flush},  {1'b0, e.fl});
            chk("halted",      vec_id, {1'b0, bus_if.o_halted},       {1'b0, e.hl});
            chk("stall_count", vec_id, bus_if.o_stall_count,          e.cnt);
            vec_id++;
        end
    end

    task automatic step(input logic r, input logic en, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rtex, input logic mem,
                        input logic br, input logic halt, input logic pc, input logic ifid,
                        input logic bub, input logic fl, input logic hl, input int n);
        exp_t e;
        @(posedge clk);
        #1;
        rst                     = r;
        bus_if.i_enable          = en;
        bus_if.i_rs_if_id        = rs;
        bus_if.i_rt_if_id        = rt;
        bus_if.i_rt_id_ex        = rtex;
        bus_if.i_mem_read_id_ex  = mem;
        bus_if.i_branch_taken_id = br;
        bus_if.i_halt_id         = halt;
        e = '{pc: pc, ifid: ifid, bub: bub, fl: fl, hl: hl, cnt: ec(n)};
        exp_q.push_back(e);
    endtask

    task automatic do_rst();
        step(1, 1, 1, 2, 3, 0, 0, 0,  0, 0, 1, 1, 0, 0);
    endtask

    task automatic idle(input logic hl, input int n);
        step(0, 1, 1, 2, 3, 0, 0, 0,  1, 1, 0, 0, hl, n);
    endtask

    initial begin
        int waited;
        rst = 1'b1;
        bus_if.i_enable = 1'b0;
        do_rst();
        do_rst();
        idle(0, 0);
        // load-use on rs, then the one-cycle stall release
        step(0, 1, 8, 2, 8, 1, 0, 0,  0, 0, 1, 0, 0, 0);
        step(0, 1, 8, 2, 8, 1, 0, 0,  1, 1, 0, 0, 0, 1);
        // load into r0 never stalls
        step(0, 1, 0, 2, 0, 1, 0, 0,  1, 1, 0, 0, 0, 1);
        // taken branch flushes
        step(0, 1, 1, 2, 3, 0, 1, 0,  1, 1, 0, 1, 0, 1);
        // load-use on rt beats branch; branch acted on in LOAD_STALL
        step(0, 1, 1, 5, 5, 1, 1, 0,  0, 0, 1, 0, 0, 1);
        step(0, 1, 1, 5, 5, 1, 1, 0,  1, 1, 0, 1, 0, 2);
        // load-use beats halt; halt decoded in LOAD_STALL
        step(0, 1, 7, 1, 7, 1, 0, 1,  0, 0, 1, 0, 0, 2);
        step(0, 1, 7, 1, 7, 1, 0, 1,  0, 1, 0, 1, 0, 3);
        // drain: one enabled cycle, five frozen cycles, then two more enabled
        step(0, 1, 1, 2, 3, 0, 0, 0,  0, 1, 0, 1, 0, 3);
        for (int i = 0; i < 5; i++) step(0, 0, 4, 4, 4, 1, 1, 1,  0, 0, 0, 0, 0, 3);
        step(0, 1, 4, 4, 4, 1, 1, 0,  0, 1, 0, 1, 0, 3);
        step(0, 1, 1, 2, 3, 0, 0, 0,  0, 1, 0, 1, 0, 3);
        // halted holds regardless of inputs or enable
        step(0, 1, 4, 4, 4, 1, 1, 1,  0, 0, 0, 0, 1, 3);
        step(0, 0, 1, 2, 3, 0, 0, 0,  0, 0, 0, 0, 1, 3);
        step(0, 1, 1, 2, 3, 0, 0, 0,  0, 0, 0, 0, 1, 3);
        do_rst();
        idle(0, 0);
        // disabled cycle with a hazard present
        step(0, 0, 8, 2, 8, 1, 0, 0,  0, 0, 0, 0, 0, 0);
        // reset mid-drain leaves no residual drain
        step(0, 1, 1, 2, 3, 0, 0, 1,  0, 1, 0, 1, 0, 0);
        step(0, 1, 1, 2, 3, 0, 0, 0,  0, 1, 0, 1, 0, 0);
        do_rst();
        for (int i = 0; i < 4; i++) idle(0, 0);
        // five separate stalls against a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 3, 9, 3, 1, 0, 0,  0, 0, 1, 0, 0, i);
            step(0, 1, 3, 9, 3, 1, 0, 0,  1, 1, 0, 0, 0, i + 1);
            idle(0, i + 1);
        end
        idle(0, 5);
        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain_queue: %0d entries left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
